// File: rtl/blk_mem_pkg.sv
// Shared widths, field positions and cache-line layout for blk_mem_gen.
package blk_mem_pkg;

    localparam int VALID_BIT = 541;
    localparam int TAG_HI    = 540;
    localparam int TAG_LO    = 512;
    localparam int DATA_HI   = 511;

    localparam int DATA_W = VALID_BIT + 1;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8192;

    typedef struct packed {
        logic                     valid;
        logic [TAG_HI-TAG_LO:0]   tag;
        logic [DATA_HI:0]         data;
    } cache_line_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

endpackage

// File: rtl/blk_mem_if.sv
// Port A bundle of the cache-line RAM: controller is master, RAM is slave.
interface blk_mem_if;
    import blk_mem_pkg::*;

    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (
        output ena, wea, addra, dina,
        input  douta
    );

    modport slave (
        input  ena, wea, addra, dina,
        output douta
    );

endinterface

// File: rtl/blk_mem_out_reg.sv
// Optional output register; loads only when the previous cycle was an
// enabled access, so douta holds while the port is idle.
module blk_mem_out_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ena,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic         r_en_d;
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_en_d <= 1'b0;
            r_q    <= '0;
        end else begin
            r_en_d <= i_ena;
            if (r_en_d)
                r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/blk_mem_gen.sv
// Single-port write-first cache-line RAM, 542 x 8192.
// Define BLK_MEM_OUTREG_EN for the registered output (latency 2, else 1).
module blk_mem_gen
    import blk_mem_pkg::*;
(
    input  logic      clka,
    input  logic      rsta_n,
    blk_mem_if.slave  port_a
);

    // No reset on the array so it maps onto block RAM; contents start zero
    // from device configuration.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd;
    logic [DATA_W-1:0] w_dout;
    logic              w_in_rng;

    assign w_in_rng = in_range(port_a.addra);

    always_ff @(posedge clka) begin
        if (port_a.ena && port_a.wea && w_in_rng)
            r_mem[port_a.addra] <= port_a.dina;
    end

    always_ff @(posedge clka) begin
        if (!rsta_n)
            r_rd <= '0;
        else if (port_a.ena) begin
            if (port_a.wea)
                r_rd <= port_a.dina;
            else if (w_in_rng)
                r_rd <= r_mem[port_a.addra];
            else
                r_rd <= '0;
        end
    end

`ifdef BLK_MEM_OUTREG_EN
    blk_mem_out_reg #(
        .W (DATA_W)
    ) u_out_reg (
        .i_clk   (clka),
        .i_rst_n (rsta_n),
        .i_ena   (port_a.ena),
        .i_d     (r_rd),
        .o_q     (w_dout)
    );
`else
    assign w_dout = r_rd;
`endif

    assign port_a.douta = w_dout;

endmodule

// File: tb/tb_blk_mem_gen.sv
// Scoreboard bench for blk_mem_gen: stimulus queues expected douta per cycle,
// a negedge monitor pops and compares.
module tb_blk_mem_gen;
    import blk_mem_pkg::*;

`ifdef BLK_MEM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic clka;
    logic rsta_n;
    blk_mem_if bus ();

    blk_mem_gen dut (
        .clka   (clka),
        .rsta_n (rsta_n),
        .port_a (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int                checks   = 0;
    int                failures = 0;
    int                q_at  [$];
    logic [DATA_W-1:0] q_val [$];
    string             q_nm  [$];
    logic [DATA_W-1:0] last;

    cache_line_t line_a, pat_b, line_c, line_d, junk;

    always @(negedge clka) begin : mon
        int                at;
        logic [DATA_W-1:0] v;
        string             nm;
        while (q_at.size() > 0 && q_at[0] <= cyc) begin
            at = q_at.pop_front();
            v  = q_val.pop_front();
            nm = q_nm.pop_front();
            checks++;
            if (at != cyc) begin
                failures++;
                $display("FAIL %s: missed slot cyc=%0d now=%0d", nm, at, cyc);
            end else if (bus.douta !== v) begin
                failures++;
                $display("FAIL %s: douta=%h want=%h", nm, bus.douta, v);
            end
        end
    end

    task automatic drive(input logic en, input logic we,
                         input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic rst);
        @(negedge clka);
        bus.ena   = en;
        bus.wea   = we;
        bus.addra = a;
        bus.dina  = d;
        rsta_n    = ~rst;
    endtask

    task automatic expect_at(input int off, input logic [DATA_W-1:0] v,
                             input string nm);
        q_at.push_back(cyc + off);
        q_val.push_back(v);
        q_nm.push_back(nm);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] e, input string nm);
        drive(1'b1, 1'b0, a, '0, 1'b0);
        expect_at(L, e, nm);
        last = e;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input string nm);
        drive(1'b1, 1'b1, a, d, 1'b0);
        expect_at(L, d, nm);
        last = d;
    endtask

    task automatic idle(input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input string nm);
        drive(1'b0, we, a, d, 1'b0);
        expect_at(L, last, nm);
    endtask

    initial begin
        line_a = '{valid: 1'b1, tag: 29'h1ABCDEF0, data: {64{8'hA5}}};
        pat_b  = '{valid: 1'b1, tag: 29'h00001FFF, data: {16{32'hDEADBEEF}}};
        line_c = '{valid: 1'b1, tag: 29'h00000007,
                   data: {8{64'h0123456789ABCDEF}}};
        line_d = '{valid: 1'b1, tag: 29'h00000009, data: {128{4'h9}}};
        junk   = '1;
        last   = '0;

        rsta_n    = 1'b0;
        bus.ena   = 1'b0;
        bus.wea   = 1'b0;
        bus.addra = '0;
        bus.dina  = '0;

        drive(1'b0, 1'b0, '0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        expect_at(1, '0, "reset_douta");

        rd(13'h0000, '0, "init_rd0");
        rd(13'h0001, '0, "init_rd1");
        rd(13'h1FFF, '0, "init_rd8191");

        wr(13'h0005, line_a, "wr5_first");
        rd(13'h0005, line_a, "rd5");

        wr(13'h1FFF, pat_b, "wr1fff_first");
        rd(13'h0000, '0, "rd0_b2b");
        rd(13'h1FFF, pat_b, "rd1fff_b2b");

        idle(1'b1, 13'h0010, junk, "ena0_wr_hold");
        rd(13'h1FFF, pat_b, "rd1fff_again");
        idle(1'b0, 13'h0000, '0, "hold1");
        idle(1'b0, 13'h0000, '0, "hold2");
        idle(1'b0, 13'h0000, '0, "hold3");
        rd(13'h0010, '0, "rd10_unwritten");

        rd(13'h0005, line_a, "rd5_inflight");
        drive(1'b1, 1'b1, 13'h0007, line_c, 1'b0);
`ifndef BLK_MEM_OUTREG_EN
        expect_at(L, line_c, "wr7_first");
`endif
        drive(1'b1, 1'b1, 13'h0009, line_d, 1'b1);
        expect_at(1, '0, "reset_clears");
        last = '0;
        idle(1'b0, 13'h0000, '0, "post_rst_hold");
        rd(13'h0007, line_c, "rd7_after_rst");
        rd(13'h0009, line_d, "rd9_wr_in_rst");
        rd(13'h0005, line_a, "rd5_kept");

        drive(1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 20 && q_at.size() > 0; i++)
            @(negedge clka);
        #1;
        while (q_at.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s: never compared, slot cyc=%0d", q_nm[0], q_at[0]);
            void'(q_at.pop_front());
            void'(q_val.pop_front());
            void'(q_nm.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
